// File: rtl/mem_arbiter_if.sv
// Bundle of requester, write-buffer and physical-memory signals around mem_arbiter.
// master is the arbiter side; slave is the caches/write buffer/memory side.
interface mem_arbiter_if;
    logic         i_req;
    logic [11:0]  i_addr;
    logic [127:0] i_rdata;
    logic         i_ack;
    logic         d_req;
    logic [11:0]  d_addr;
    logic [127:0] d_rdata;
    logic         d_ack;
    logic         wb_req;
    logic         wb_full;
    logic [11:0]  wb_addr;
    logic [127:0] wb_wdata;
    logic         wb_ack;
    logic         mem_read;
    logic         mem_write;
    logic [11:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_resp;

    modport master (
        input  i_req, i_addr, d_req, d_addr,
        input  wb_req, wb_full, wb_addr, wb_wdata,
        input  mem_rdata, mem_resp,
        output i_rdata, i_ack, d_rdata, d_ack, wb_ack,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_addr,
        output wb_req, wb_full, wb_addr, wb_wdata,
        output mem_rdata, mem_resp,
        input  i_rdata, i_ack, d_rdata, d_ack, wb_ack,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one physical-memory line port among I-miss, D-miss and write-buffer drain.
// Reads beat drains unless the buffer is full, starving, or holds a line being read.
module mem_arbiter #(
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, IREAD, DREAD, WRITE} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t       state;
    logic         last_rd;
    logic [3:0]   starve_cnt;
    logic [11:0]  addr_q;
    logic [127:0] wdata_q;

    logic hazard, force_wr, grant_wr, grant_i, grant_d;

    always_comb begin
        hazard   = (bus.i_req && (bus.i_addr == bus.wb_addr)) ||
                   (bus.d_req && (bus.d_addr == bus.wb_addr));
        force_wr = bus.wb_req && (bus.wb_full || (starve_cnt == STARVE_LIM) || hazard);
        grant_wr = 1'b0;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        if (force_wr) begin
            grant_wr = 1'b1;
        end else if (bus.i_req && bus.d_req) begin
            // tie goes to whichever side did not win the last read
            grant_i = last_rd;
            grant_d = !last_rd;
        end else if (bus.i_req) begin
            grant_i = 1'b1;
        end else if (bus.d_req) begin
            grant_d = 1'b1;
        end else if (bus.wb_req) begin
            grant_wr = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_rd    <= 1'b1;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            if (!bus.wb_req) starve_cnt <= '0;
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        state      <= WRITE;
                        addr_q     <= bus.wb_addr;
                        wdata_q    <= bus.wb_wdata;
                        starve_cnt <= '0;
                    end else if (grant_i || grant_d) begin
                        state   <= grant_i ? IREAD : DREAD;
                        addr_q  <= grant_i ? bus.i_addr : bus.d_addr;
                        last_rd <= grant_d;
                        if (bus.wb_req && (starve_cnt != STARVE_LIM))
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                default: begin
                    if (bus.mem_resp) state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_read  = (state == IREAD) || (state == DREAD);
        bus.mem_write = (state == WRITE);
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.i_ack     = (state == IREAD) && bus.mem_resp;
        bus.d_ack     = (state == DREAD) && bus.mem_resp;
        bus.wb_ack    = (state == WRITE) && bus.mem_resp;
        bus.i_rdata   = bus.mem_rdata;
        bus.d_rdata   = bus.mem_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: ties, hazard, starvation, wb_full, reset mid-transfer.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // kind: 1=IREAD 2=DREAD 3=WRITE. Waits for the grant, holds for lat cycles, responds.
    task automatic serve(input string tag, input int kind, input logic [11:0] addr,
                         input int lat, input logic [127:0] rd, input logic [127:0] wd,
                         input bit drop);
        int n = 0;
        logic [1:0] exp_sb;
        exp_sb = (kind == 3) ? 2'b10 : 2'b01;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.mem_read || bus.mem_write) && n < 20);
        check({tag, "_strobe"}, {126'd0, bus.mem_write, bus.mem_read}, {126'd0, exp_sb});
        check({tag, "_addr"}, bus.mem_addr, addr);
        if (kind == 3) check({tag, "_wdata"}, bus.mem_wdata, wd);
        repeat (lat - 1) begin
            check({tag, "_noack"}, {bus.i_ack, bus.d_ack, bus.wb_ack}, 3'b000);
            @(negedge clk);
            check({tag, "_hold"}, {114'd0, bus.mem_write, bus.mem_read, bus.mem_addr},
                  {114'd0, exp_sb, addr});
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rd;
        #1;
        check({tag, "_ack"}, {bus.i_ack, bus.d_ack, bus.wb_ack},
              {kind == 1, kind == 2, kind == 3});
        if (kind == 1) check({tag, "_irdata"}, bus.i_rdata, rd);
        if (kind == 2) check({tag, "_drdata"}, bus.d_rdata, rd);
        @(negedge clk);
        bus.mem_resp = 1'b0;
        if (drop) begin
            if (kind == 1) bus.i_req = 1'b0;
            if (kind == 2) bus.d_req = 1'b0;
            if (kind == 3) bus.wb_req = 1'b0;
        end
        check({tag, "_idle"}, {bus.mem_write, bus.mem_read, bus.i_ack, bus.d_ack, bus.wb_ack}, 5'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a_line, b_line, w_line;
        int n;
        a_line = {4{32'hA5A5_1234}};
        b_line = {4{32'h0BAD_F00D}};
        w_line = {4{32'hC0DE_7777}};

        rst = 1'b1;
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_addr = '0;
        bus.wb_req = 0; bus.wb_full = 0; bus.wb_addr = '0; bus.wb_wdata = '0;
        bus.mem_rdata = b_line; bus.mem_resp = 0;
        repeat (2) @(negedge clk);
        check("rst_strobes", {bus.mem_read, bus.mem_write, bus.i_ack, bus.d_ack, bus.wb_ack}, 5'b0);
        check("rst_addr", bus.mem_addr, 12'h000);
        check("rst_wdata", bus.mem_wdata, '0);
        check("rst_irdata", bus.i_rdata, b_line);
        rst = 1'b0;

        // tie from reset: I first, then alternating
        bus.i_req = 1; bus.i_addr = 12'h111; bus.d_req = 1; bus.d_addr = 12'h222;
        serve("tie1_i", 1, 12'h111, 1, a_line, '0, 0);
        serve("tie2_d", 2, 12'h222, 1, b_line, '0, 0);
        serve("tie3_i", 1, 12'h111, 2, b_line, '0, 0);
        serve("tie4_d", 2, 12'h222, 1, a_line, '0, 0);
        bus.i_req = 0; bus.d_req = 0;

        // single I read, 3-cycle latency
        bus.i_req = 1; bus.i_addr = 12'h123;
        serve("single_i", 1, 12'h123, 3, a_line, '0, 1);

        // response in IDLE is ignored
        @(negedge clk);
        bus.mem_resp = 1; #1;
        check("idle_resp", {bus.i_ack, bus.d_ack, bus.wb_ack, bus.mem_read, bus.mem_write}, 5'b0);
        @(negedge clk);
        bus.mem_resp = 0;
        check("idle_resp_stay", {bus.mem_read, bus.mem_write}, 2'b00);

        // address hazard: drain must precede the read of the same line
        bus.wb_req = 1; bus.wb_addr = 12'h040; bus.wb_wdata = w_line;
        bus.d_req = 1; bus.d_addr = 12'h040;
        serve("haz_wr", 3, 12'h040, 2, '0, w_line, 1);
        serve("haz_rd", 2, 12'h040, 1, w_line, '0, 1);

        // reads beat a non-urgent drain
        bus.wb_req = 1; bus.wb_addr = 12'h300; bus.wb_wdata = w_line;
        bus.i_req = 1; bus.i_addr = 12'h200;
        serve("pri_rd", 1, 12'h200, 1, a_line, '0, 1);
        serve("pri_wr", 3, 12'h300, 1, '0, w_line, 1);

        // wb_full forces the drain ahead of a pending read
        bus.wb_req = 1; bus.wb_full = 1; bus.wb_addr = 12'h301; bus.wb_wdata = b_line;
        bus.i_req = 1; bus.i_addr = 12'h201;
        serve("full_wr", 3, 12'h301, 1, '0, b_line, 1);
        bus.wb_full = 0;
        serve("full_rd", 1, 12'h201, 1, a_line, '0, 1);

        // starvation: 8 reads then a forced drain, twice (counter restarts at 0)
        bus.wb_req = 1; bus.wb_addr = 12'h7F0; bus.wb_wdata = w_line;
        bus.i_req = 1; bus.i_addr = 12'h010;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) serve("starve_rd", 1, 12'h010, 1, a_line, '0, 0);
            serve("starve_wr", 3, 12'h7F0, 1, '0, w_line, 0);
        end
        bus.wb_req = 0; bus.i_req = 0;

        // reset two cycles into a D read
        bus.d_req = 1; bus.d_addr = 12'h0AB;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_read && n < 20);
        check("rstmid_grant", {bus.mem_read, bus.mem_addr}, {1'b1, 12'h0AB});
        @(negedge clk);
        rst = 1; bus.mem_resp = 1; #1;
        check("rstmid_drop", {bus.mem_read, bus.mem_write, bus.d_ack}, 3'b000);
        @(negedge clk);
        rst = 0; bus.mem_resp = 0;
        serve("rstmid_regrant", 2, 12'h0AB, 2, b_line, '0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
